// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
//   state_t : arbiter FSM state encodings
//   owner_t : grant owner encodings (CPU / external port)
//   cnt_width() : counter width for a given maximum value (minimum 1 bit)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the memory and the arbiter.
//   master : requester/memory side (drives req fields and mem_rdata)
//   slave  : arbiter side (drives acks, read data, stall, memory strobes, owner)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  ext_ack, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  owner
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    output ext_ack, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output owner
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Priority decision plus starvation counter for the memory port arbiter.
//   i_clk, i_rst      : clock, async active-high reset
//   i_cpu_req/ext_req : pending requests
//   i_eval            : high while the arbiter is in IDLE and may grant
//   o_grant_valid_c   : a grant is made this cycle (combinational)
//   o_grant_owner_c   : winner of this cycle's arbitration (combinational)
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_cpu_req,
  input  logic   i_ext_req,
  input  logic   i_eval,
  output logic   o_grant_valid_c,
  output owner_t o_grant_owner_c
);

  localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;
  logic             w_ext_wins;

  assign w_starved       = (r_starve_cnt == CNT_W'(STARVE_MAX));
  // CPU has priority unless ext has lost STARVE_MAX arbitrations in a row.
  assign w_ext_wins      = i_ext_req & (~i_cpu_req | w_starved);
  assign o_grant_valid_c = i_eval & (i_cpu_req | i_ext_req);
  assign o_grant_owner_c = w_ext_wins ? OWN_EXT : OWN_CPU;

  // Count CPU wins that left ext waiting; saturate, clear on ext grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (o_grant_valid_c) begin
      if (w_ext_wins) begin
        r_starve_cnt <= '0;
      end else if (i_ext_req && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU datapath and an external requester.
// Serialises transactions, absorbs the fixed memory read latency and stalls
// the CPU until its access completes.
//   i_clk, i_rst : clock, async active-high reset
//   io_bus       : slave side of mem_port_arbiter_if (requests, acks, read
//                  data, cpu_stall, memory strobes, owner)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mem_port_arbiter_if.slave   io_bus
);

  localparam int unsigned WAIT_W = cnt_width(MEM_LAT - 1);

  state_t            r_state;
  owner_t            r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata_q;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_ack;
  logic              r_ext_ack;

  logic              w_eval;
  logic              w_grant_valid;
  owner_t            w_grant_owner;
  logic              w_win_ext;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  assign w_eval = (r_state == IDLE);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_cpu_req       (io_bus.cpu_req),
    .i_ext_req       (io_bus.ext_req),
    .i_eval          (w_eval),
    .o_grant_valid_c (w_grant_valid),
    .o_grant_owner_c (w_grant_owner)
  );

  // Request fields of the arbitration winner.
  assign w_win_ext   = (w_grant_owner == OWN_EXT);
  assign w_win_we    = w_win_ext ? io_bus.ext_we    : io_bus.cpu_we;
  assign w_win_addr  = w_win_ext ? io_bus.ext_addr  : io_bus.cpu_addr;
  assign w_win_wdata = w_win_ext ? io_bus.ext_wdata : io_bus.cpu_wdata;

  // Transaction FSM; memory strobes and acks are registered so they are
  // valid exactly in the ISSUE and DONE cycles respectively.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata_q   <= '0;
      r_wait_cnt  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_ext_ack   <= 1'b0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_ext_ack   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner     <= w_grant_owner;
            r_we        <= w_win_we;
            r_addr      <= w_win_addr;
            r_wdata     <= w_win_wdata;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_win_we;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
            r_state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (r_we) begin
            // Write commits during ISSUE; acknowledge next cycle.
            r_cpu_ack <= (r_owner == OWN_CPU);
            r_ext_ack <= (r_owner == OWN_EXT);
            r_state   <= DONE;
          end else begin
            r_wait_cnt <= WAIT_W'(MEM_LAT - 1);
            r_state    <= WAIT;
          end
        end

        WAIT: begin
          if (r_wait_cnt == '0) begin
            r_rdata_q <= io_bus.mem_rdata;
            r_cpu_ack <= (r_owner == OWN_CPU);
            r_ext_ack <= (r_owner == OWN_EXT);
            r_state   <= DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_bus.cpu_ack   = r_cpu_ack;
  assign io_bus.ext_ack   = r_ext_ack;
  assign io_bus.cpu_rdata = r_rdata_q;
  assign io_bus.ext_rdata = r_rdata_q;
  // Only combinational output: lets the control FSM hold in the same cycle.
  assign io_bus.cpu_stall = io_bus.cpu_req & ~r_cpu_ack;
  assign io_bus.mem_en    = r_mem_en;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned SM  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MEM_LAT    (LAT),
    .STARVE_MAX (SM)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model (fixed 2-cycle read latency) ----------------
  logic [15:0] mem_tb [logic [15:0]];
  logic [15:0] p0 = 16'h0;
  logic [15:0] p1 = 16'h0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : ((a ^ 16'h5A5A) + 16'h0101);
  endfunction

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return mem_tb.exists(a) ? mem_tb[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem_tb[bus.mem_addr] = bus.mem_wdata;
    p0 <= (bus.mem_en && !bus.mem_we) ? rd_mem(bus.mem_addr) : 16'($urandom);
    p1 <= p0;
  end
  assign bus.mem_rdata = p1;

  // ---------------- transaction-level reference model ----------------
  logic [15:0] shadow [logic [15:0]];

  function automatic logic [15:0] sh_rd(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  int          cyc = 0;
  bit          m_busy = 0;
  int          m_t0 = 0;
  int          m_len = 0;
  bit          m_own = 0;
  bit          m_we = 0;
  logic [15:0] m_addr = 0, m_wdata = 0, m_rval = 0;
  bit          m_last_own = 0;
  logic [15:0] m_last_rdata = 0;
  int          m_starve = 0;
  int          m_acks = 0;

  always @(negedge clk) begin : model
    int k;
    logic e_en, e_we, e_ca, e_ea, e_own;
    logic [15:0] e_addr, e_wd, e_rd;
    e_en = 0; e_we = 0; e_ca = 0; e_ea = 0;
    e_addr = 0; e_wd = 0;
    k = cyc - m_t0;
    if (rst) begin
      e_own = 0;
      e_rd  = 0;
    end else begin
      e_own = m_busy ? m_own : m_last_own;
      e_rd  = m_last_rdata;
      if (m_busy) begin
        // Cycle k after the sampling IDLE cycle: ISSUE at 1, ack at len-1.
        if (k == 1) begin
          e_en = 1; e_we = m_we; e_addr = m_addr; e_wd = m_wdata;
        end
        if (k == m_len - 1) begin
          e_ca = !m_own;
          e_ea = m_own;
          if (!m_we) e_rd = m_rval;
        end
      end
    end

    chk("mdl.mem_en",    32'(bus.mem_en),    32'(e_en));
    chk("mdl.mem_we",    32'(bus.mem_we),    32'(e_we));
    chk("mdl.mem_addr",  32'(bus.mem_addr),  32'(e_addr));
    chk("mdl.mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
    chk("mdl.cpu_ack",   32'(bus.cpu_ack),   32'(e_ca));
    chk("mdl.ext_ack",   32'(bus.ext_ack),   32'(e_ea));
    chk("mdl.owner",     32'(bus.owner),     32'(e_own));
    chk("mdl.cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rd));
    chk("mdl.ext_rdata", 32'(bus.ext_rdata), 32'(e_rd));
    chk("mdl.cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req & ~e_ca));

    if (rst) begin
      m_busy = 0; m_last_own = 0; m_last_rdata = 0; m_starve = 0;
    end else if (m_busy) begin
      if (k == 1 && m_we) shadow[m_addr] = m_wdata;
      if (k == m_len - 1) begin
        m_busy     = 0;
        m_last_own = m_own;
        if (!m_we) m_last_rdata = m_rval;
        m_acks++;
      end
    end else if (bus.cpu_req || bus.ext_req) begin
      m_own = bus.ext_req && (!bus.cpu_req || m_starve == int'(SM));
      if (m_own) m_starve = 0;
      else if (bus.ext_req && m_starve < int'(SM)) m_starve++;
      m_we    = m_own ? bus.ext_we    : bus.cpu_we;
      m_addr  = m_own ? bus.ext_addr  : bus.cpu_addr;
      m_wdata = m_own ? bus.ext_wdata : bus.cpu_wdata;
      m_rval  = sh_rd(m_addr);
      m_len   = m_we ? 3 : int'(LAT) + 3;
      m_t0    = cyc;
      m_busy  = 1;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_gap();
    bus.cpu_req = 0;
    bus.ext_req = 0;
    nxt();
  endtask

  task automatic rnd_port(input logic acked, inout logic req, inout logic we,
                          inout logic [15:0] addr, inout logic [15:0] wdata);
    if (req) begin
      if (acked) begin
        if ($urandom_range(0, 1) == 1) begin
          we = 1'($urandom_range(0, 1)); addr = 16'($urandom_range(0, 31)); wdata = 16'($urandom);
        end else begin
          req = 0;
        end
      end else if ($urandom_range(0, 39) == 0) begin
        req = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        addr = 16'($urandom_range(0, 31)); wdata = 16'($urandom);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      req = 1;
      we = 1'($urandom_range(0, 1)); addr = 16'($urandom_range(0, 31)); wdata = 16'($urandom);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  acks_seen, budget, last_ack;
    logic who;
    logic ca, ea;
    logic cr, cw, er, ew;
    logic [15:0] caddr, cwd, eaddr, ewd;

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state.
    neg();
    chk("rst.owner", 32'(bus.owner), 32'h0);
    chk("rst.mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst.rdata", 32'(bus.cpu_rdata), 32'h0);
    nxt();

    // 1: CPU read of 0x0010 returning 0xBEEF.
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0010;
    for (int k = 0; k < 5; k++) begin
      neg();
      if (k < 4) chk("t1.stall", 32'(bus.cpu_stall), 32'h1);
      if (k == 1) begin
        chk("t1.mem_en", 32'(bus.mem_en), 32'h1);
        chk("t1.mem_addr", 32'(bus.mem_addr), 32'h0010);
        chk("t1.mem_we", 32'(bus.mem_we), 32'h0);
      end
      if (k == 4) begin
        chk("t1.ack", 32'(bus.cpu_ack), 32'h1);
        chk("t1.rdata", 32'(bus.cpu_rdata), 32'hBEEF);
        chk("t1.stall_ack", 32'(bus.cpu_stall), 32'h0);
      end else begin
        chk("t1.noack", 32'(bus.cpu_ack), 32'h0);
      end
      nxt();
    end
    idle_gap();

    // 2: ext write of 0x1234 to 0x00FF.
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 16'h00FF; bus.ext_wdata = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      neg();
      if (k == 1) begin
        chk("t2.mem_en", 32'(bus.mem_en), 32'h1);
        chk("t2.mem_we", 32'(bus.mem_we), 32'h1);
        chk("t2.mem_addr", 32'(bus.mem_addr), 32'h00FF);
        chk("t2.mem_wdata", 32'(bus.mem_wdata), 32'h1234);
      end
      chk("t2.ext_ack", 32'(bus.ext_ack), (k == 2) ? 32'h1 : 32'h0);
      chk("t2.cpu_ack", 32'(bus.cpu_ack), 32'h0);
      nxt();
    end
    idle_gap();

    // 4: CPU read of 0x0020 with cpu_addr changed in cycle 2.
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0020;
    for (int k = 0; k < 5; k++) begin
      neg();
      if (k == 1) chk("t4.mem_addr", 32'(bus.mem_addr), 32'h0020);
      chk("t4.ack", 32'(bus.cpu_ack), (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) chk("t4.rdata", 32'(bus.cpu_rdata), 32'h5B7B);
      nxt();
      if (k == 1) bus.cpu_addr = 16'h0030;
    end
    idle_gap();

    // 5: ext read of 0x0040, reset in cycle 2, then completes normally.
    bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 16'h0040;
    neg(); nxt();
    neg();
    chk("t5.owner_pre", 32'(bus.owner), 32'h1);
    chk("t5.rdata_pre", 32'(bus.ext_rdata), 32'h5B7B);
    nxt();
    rst = 1;
    neg();
    chk("t5.rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("t5.rst_ack", 32'(bus.ext_ack), 32'h0);
    chk("t5.rst_owner", 32'(bus.owner), 32'h0);
    chk("t5.rst_rdata", 32'(bus.ext_rdata), 32'h0);
    nxt();
    rst = 0;
    for (int j = 0; j < 5; j++) begin
      neg();
      chk("t5.ack", 32'(bus.ext_ack), (j == 4) ? 32'h1 : 32'h0);
      if (j == 4) chk("t5.rdata", 32'(bus.ext_rdata), 32'h5B1B);
      nxt();
    end
    idle_gap();

    // 3: both requesters held high: four CPU grants, then one ext grant.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0100; bus.cpu_wdata = 16'hC0DE;
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 16'h0200; bus.ext_wdata = 16'hE0E0;
    acks_seen = 0; budget = 0; last_ack = -1;
    while (acks_seen < 10 && budget < 100) begin
      neg();
      if (bus.cpu_ack || bus.ext_ack) begin
        who = bus.ext_ack;
        chk("t3.grant", 32'(who), (acks_seen % 5 == 4) ? 32'h1 : 32'h0);
        if (last_ack >= 0) chk("t3.spacing", 32'(budget - last_ack), 32'd3);
        last_ack = budget;
        acks_seen++;
      end
      budget++;
      nxt();
    end
    chk("t3.count", 32'(acks_seen), 32'd10);
    idle_gap();

    // 6: CPU write request held across acks: ISSUE at 1,4,7,10; ack at 2,5,8,11.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0008; bus.cpu_wdata = 16'hA5A5;
    for (int c = 0; c < 12; c++) begin
      neg();
      chk("t6.mem_en", 32'(bus.mem_en), (c % 3 == 1) ? 32'h1 : 32'h0);
      chk("t6.ack", 32'(bus.cpu_ack), (c % 3 == 2) ? 32'h1 : 32'h0);
      nxt();
    end
    idle_gap();

    // Randomized traffic with occasional resets.
    cr = 0; cw = 0; caddr = 0; cwd = 0;
    er = 0; ew = 0; eaddr = 0; ewd = 0;
    for (int c = 0; c < 3000; c++) begin
      neg();
      ca = bus.cpu_ack;
      ea = bus.ext_ack;
      nxt();
      if (rst) rst = 0;
      else if ($urandom_range(0, 599) == 0) rst = 1;
      rnd_port(ca, cr, cw, caddr, cwd);
      rnd_port(ea, er, ew, eaddr, ewd);
      bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
      bus.ext_req = er; bus.ext_we = ew; bus.ext_addr = eaddr; bus.ext_wdata = ewd;
    end
    rst = 0;
    idle_gap();
    repeat (8) nxt();
    chk("rnd.activity", 32'(m_acks > 300), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
